// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Strobes are decoded from the registered state plus live inputs. A memory
// wait watchdog halts the machine with a sticky bus error if memory stalls.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        halted,
  output logic        bus_err,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_LAST_RTYPE = 4'd4;
  localparam logic [3:0] OP_BNE        = 4'd5;
  localparam logic [3:0] OP_LOAD       = 4'd6;
  localparam logic [3:0] OP_HALT       = 4'd15;
  localparam logic [3:0] WAIT_LIMIT    = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [15:0] instrCount_q, instrCount_d;
  logic        busErr_q, busErr_d;
  logic        retire;
  logic        timeout;

  // Next-state, strobe decode, watchdog and retire counting
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end
      end
      DECODE: begin
        opcode_d = opcode;
        if (opcode <= OP_LOAD) begin
          state_d = EXEC;
        end else if (opcode == OP_HALT) begin
          retire  = 1'b1;
          state_d = HALT;
        end else begin
          illegal = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_src = 1'b1;
        if (opcode_q <= OP_LAST_RTYPE) begin
          state_d = WB;
        end else if (opcode_q == OP_BNE) begin
          if (!zero_flag) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          retire  = 1'b1;
          state_d = FETCH;
        end else if (opcode_q == OP_LOAD) begin
          state_d = MEM;
        end else begin
          state_d = HALT;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        alu_src      = 1'b1;
        if (mem_ready) begin
          state_d = WB;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_q == OP_LOAD);
        retire     = 1'b1;
        state_d    = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = HALT;
      end
    endcase

    // Strobes must stay quiet while reset is held, even though FETCH decodes run
    if (!rst_n) begin
      mem_req   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
    end

    // Watchdog: the sixteenth stalled request cycle aborts into HALT
    if (mem_req && !mem_ready && (waitCnt_q == WAIT_LIMIT)) begin
      timeout = 1'b1;
      state_d = HALT;
    end

    waitCnt_d    = (mem_req && !mem_ready) ? waitCnt_q + 4'd1 : 4'd0;
    busErr_d     = busErr_q | timeout;
    instrCount_d = retire ? instrCount_q + 16'd1 : instrCount_q;
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      opcode_q     <= 4'd0;
      waitCnt_q    <= 4'd0;
      instrCount_q <= 16'd0;
      busErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      waitCnt_q    <= waitCnt_d;
      instrCount_q <= instrCount_d;
      busErr_q     <= busErr_d;
    end
  end

  assign bus_err     = busErr_q;
  assign state       = state_q;
  assign instr_count = instrCount_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with hand-computed strobe patterns.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [3:0]  opcode;
  logic        zero_flag;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_addr_sel;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        alu_src;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;
  logic        halted;
  logic        bus_err;
  logic [2:0]  state;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Strobe vector bit order: req, addrSel, irWrite, pcWrite, pcSrc, aluSrc,
  // regWrite, memToReg, illegal, halted, busErr
  localparam logic [10:0] S_IDLE     = 11'b000_0000_0000;
  localparam logic [10:0] S_FETCH_OK = 11'b101_1000_0000;
  localparam logic [10:0] S_FETCH_WT = 11'b100_0000_0000;
  localparam logic [10:0] S_EXEC     = 11'b000_0010_0000;
  localparam logic [10:0] S_BNE_TAKE = 11'b000_1110_0000;
  localparam logic [10:0] S_MEM      = 11'b110_0010_0000;
  localparam logic [10:0] S_WB_R     = 11'b000_0001_0000;
  localparam logic [10:0] S_WB_LD    = 11'b000_0001_1000;
  localparam logic [10:0] S_ILL      = 11'b000_0000_0100;
  localparam logic [10:0] S_HALT     = 11'b000_0000_0010;
  localparam logic [10:0] S_HALT_ERR = 11'b000_0000_0011;

  multicycle_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .zero_flag    (zero_flag),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .illegal      (illegal),
    .halted       (halted),
    .bus_err      (bus_err),
    .state        (state),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] strobes();
    return {mem_req, mem_addr_sel, ir_write, pc_write, pc_src, alu_src,
            reg_write, mem_to_reg, illegal, halted, bus_err};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [2:0] expState, input logic [10:0] expStrobes);
    checkOutput({tag, " state"}, {29'd0, state}, {29'd0, expState});
    checkOutput({tag, " strobes"}, {21'd0, strobes()}, {21'd0, expStrobes});
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] op, input logic z, input logic rdy);
    @(negedge clk);
    run       = r;
    opcode    = op;
    zero_flag = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic resetPulse(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    run       = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkCycle({tag, " in reset"}, 3'd0, S_IDLE);
    checkOutput({tag, " count in reset"}, {16'd0, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b0;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b1;
    opcode    = 4'd0;
    zero_flag = 1'b0;
    mem_ready = 1'b1;
    #2;
    checkCycle("reset", 3'd0, S_IDLE);
    checkOutput("reset count", {16'd0, instr_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b0;

    // R-type opcode 2; opcode changes after DECODE must be ignored
    applyStimulus(1, 4'd2, 0, 1); checkCycle("rtype c0", 3'd0, S_FETCH_OK);
    applyStimulus(1, 4'd2, 0, 1); checkCycle("rtype c1", 3'd1, S_IDLE);
    applyStimulus(1, 4'd9, 0, 1); checkCycle("rtype c2", 3'd2, S_EXEC);
    applyStimulus(1, 4'd6, 0, 1); checkCycle("rtype c3", 3'd4, S_WB_R);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("rtype done", 3'd0, S_IDLE);
    checkOutput("rtype count", {16'd0, instr_count}, 32'd1);

    // Load with three stalled MEM cycles
    applyStimulus(1, 4'd6, 0, 1); checkCycle("load fetch", 3'd0, S_FETCH_OK);
    applyStimulus(1, 4'd6, 0, 1); checkCycle("load decode", 3'd1, S_IDLE);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("load exec", 3'd2, S_EXEC);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 4'd0, 0, 0); checkCycle("load mem wait", 3'd3, S_MEM);
    end
    applyStimulus(0, 4'd0, 0, 1); checkCycle("load mem ready", 3'd3, S_MEM);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("load wb", 3'd4, S_WB_LD);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("load done", 3'd0, S_IDLE);
    checkOutput("load count", {16'd0, instr_count}, 32'd2);

    // BNE taken then not taken
    applyStimulus(1, 4'd5, 0, 1); checkCycle("bne1 fetch", 3'd0, S_FETCH_OK);
    applyStimulus(1, 4'd5, 0, 1); checkCycle("bne1 decode", 3'd1, S_IDLE);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("bne taken exec", 3'd2, S_BNE_TAKE);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("bne1 done", 3'd0, S_IDLE);
    checkOutput("bne1 count", {16'd0, instr_count}, 32'd3);
    applyStimulus(1, 4'd5, 1, 1); checkCycle("bne2 fetch", 3'd0, S_FETCH_OK);
    applyStimulus(1, 4'd5, 1, 1); checkCycle("bne2 decode", 3'd1, S_IDLE);
    applyStimulus(0, 4'd0, 1, 0); checkCycle("bne untaken exec", 3'd2, S_EXEC);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("bne2 done", 3'd0, S_IDLE);
    checkOutput("bne2 count", {16'd0, instr_count}, 32'd4);

    // Illegal opcode 9
    applyStimulus(1, 4'd9, 0, 1); checkCycle("ill fetch", 3'd0, S_FETCH_OK);
    applyStimulus(0, 4'd9, 0, 0); checkCycle("ill decode", 3'd1, S_ILL);
    applyStimulus(0, 4'd9, 0, 0); checkCycle("ill after", 3'd0, S_IDLE);
    checkOutput("ill count", {16'd0, instr_count}, 32'd5);

    // Fetch stalls 15 cycles, ready arrives as the counter hits 15: no error
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 4'd9, 0, 0);
    end
    checkCycle("stall15 last wait", 3'd0, S_FETCH_WT);
    applyStimulus(1, 4'd9, 0, 1); checkCycle("stall15 ready", 3'd0, S_FETCH_OK);
    applyStimulus(0, 4'd9, 0, 0); checkCycle("stall15 decode", 3'd1, S_ILL);
    checkOutput("stall15 count", {16'd0, instr_count}, 32'd5);

    // Reset during a MEM wait abandons the load
    applyStimulus(1, 4'd6, 0, 1);
    applyStimulus(1, 4'd6, 0, 1);
    applyStimulus(0, 4'd0, 0, 0);
    applyStimulus(0, 4'd0, 0, 0); checkCycle("abort mem", 3'd3, S_MEM);
    #2;
    rst_n = 1'b0;
    #1;
    checkCycle("abort in reset", 3'd0, S_IDLE);
    checkOutput("abort count", {16'd0, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 4'd0, 0, 1); checkCycle("abort after", 3'd0, S_IDLE);
    applyStimulus(0, 4'd0, 0, 1); checkCycle("abort no wb", 3'd0, S_IDLE);

    // Counter wrap: deposit near the top, then retire two illegal opcodes
    dut.instrCount_q = 16'hFFFE;
    applyStimulus(1, 4'd8, 0, 1);
    applyStimulus(0, 4'd8, 0, 0);
    applyStimulus(0, 4'd0, 0, 0);
    checkOutput("wrap ffff", {16'd0, instr_count}, 32'h0000_FFFF);
    applyStimulus(1, 4'd8, 0, 1);
    applyStimulus(0, 4'd8, 0, 0);
    applyStimulus(0, 4'd0, 0, 0);
    checkOutput("wrap zero", {16'd0, instr_count}, 32'h0000_0000);

    // Halt opcode, then run/mem_ready ignored until reset
    applyStimulus(1, 4'd15, 0, 1); checkCycle("halt fetch", 3'd0, S_FETCH_OK);
    applyStimulus(1, 4'd15, 0, 1); checkCycle("halt decode", 3'd1, S_IDLE);
    applyStimulus(1, 4'd2, 0, 1); checkCycle("halt entered", 3'd5, S_HALT);
    applyStimulus(1, 4'd2, 0, 1); checkCycle("halt stays", 3'd5, S_HALT);
    checkOutput("halt count", {16'd0, instr_count}, 32'd1);
    resetPulse("halt reset");
    checkCycle("halt cleared", 3'd0, S_IDLE);

    // Memory timeout in FETCH after 16 stalled request cycles
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 4'd0, 0, 0);
    end
    checkCycle("timeout last req", 3'd0, S_FETCH_WT);
    applyStimulus(1, 4'd0, 0, 1); checkCycle("timeout halt", 3'd5, S_HALT_ERR);
    applyStimulus(1, 4'd0, 0, 1); checkCycle("timeout sticky", 3'd5, S_HALT_ERR);
    resetPulse("timeout reset");
    checkCycle("timeout cleared", 3'd0, S_IDLE);
    checkOutput("timeout count", {16'd0, instr_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 One clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  permits new instruction fetch; sampled in FETCH only.
REQ-005 opcode  input  4  opcode field from the instruction register; valid from DECODE onward.
REQ-006 zero_flag  input  1  ALU zero result; valid in EXEC.
REQ-007 mem_ready  input  1  memory completion for the current mem_req.
REQ-008 mem_req  output  1  memory access request; held until mem_ready.
REQ-009 mem_addr_sel  output  1  memory address select: 0 selects PC, 1 selects ALU result.
REQ-010 ir_write  output  1  instruction register load strobe.
REQ-011 pc_write  output  1  PC update strobe.
REQ-012 pc_src  output  1  PC source select: 0 selects PC+1, 1 selects branch target.
REQ-013 alu_src  output  1  ALU operand select: 1 selects register operand.
REQ-014 reg_write  output  1  register file write strobe.
REQ-015 mem_to_reg  output  1  write-back source select: 1 selects memory data.
REQ-016 illegal  output  1  one-cycle pulse when an unused opcode is decoded.
REQ-017 halted  output  1  high while in HALT.
REQ-018 bus_err  output  1  sticky flag for a memory timeout.
REQ-019 state  output  3  current state encoding, for debug.
REQ-020 instr_count  output  16  count of retired instructions.

Function
REQ-021 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 go to HALT on the next edge.
REQ-022 FETCH, run=0: mem_req=0, remain in FETCH.
REQ-023 FETCH, run=1: mem_req=1, mem_addr_sel=0.
REQ-024 FETCH, run=1, mem_ready=1: ir_write=1, pc_write=1, pc_src=0, same cycle; next state DECODE.
REQ-025 DECODE, opcode 0-6: go to EXEC, no strobes.
REQ-026 DECODE, opcode 7-14: illegal=1 for one cycle; instr_count+1; go to FETCH.
REQ-027 DECODE, opcode 15: go to HALT; instr_count+1.
REQ-028 EXEC, opcode 0-4 (R-type): alu_src=1; go to WB.
REQ-029 EXEC, opcode 5 (BNE): alu_src=1; pc_write=1 and pc_src=1 only when zero_flag=0; instr_count+1; go to FETCH.
REQ-030 EXEC, opcode 6 (load): alu_src=1; go to MEM.
REQ-031 MEM: mem_req=1, mem_addr_sel=1, alu_src=1; on mem_ready=1 go to WB, otherwise remain in MEM.
REQ-032 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 only for opcode 6; instr_count+1; go to FETCH.
REQ-033 All outputs are combinational decodes of the registered state plus inputs; unlisted outputs are 0 in every state.
REQ-034 opcode changes while outside FETCH/DECODE are ignored; the opcode is latched internally at DECODE.
REQ-035 Wait counter: 4-bit, cleared whenever mem_req is low or mem_ready=1, and incremented each cycle mem_req=1 with mem_ready=0.
REQ-036 Timeout: when the wait counter reaches 15 while mem_ready=0, set bus_err=1 and go to HALT on the next edge with mem_req=0.
REQ-037 mem_ready=1 in the cycle the counter reaches 15: the access completes normally and no error is raised.
REQ-038 mem_ready while mem_req=0 is ignored.
REQ-039 HALT: all strobes 0, halted=1; exit only by reset.
REQ-040 instr_count wraps from 0xFFFF to 0x0000 without a flag.
REQ-041 Minimum instruction latency: R-type 4 cycles, BNE 3 cycles, load 5 cycles, each with zero memory wait.

Reset
REQ-042 On rst_n low, asynchronously: state=FETCH, wait counter=0, instr_count=0, bus_err=0, latched opcode=0.
REQ-043 While rst_n is low, mem_req, ir_write, pc_write and reg_write are forced to 0 and halted=0.
REQ-044 Reset asserted mid-operation (including during MEM wait or HALT) abandons the instruction with no write-back strobe.
REQ-045 After rst_n rises, the first fetch occurs on the first edge with run=1.

Verification
REQ-046 run=1, mem_ready tied high, opcode=2 -> ir_write at cycle 0, reg_write at cycle 3 with mem_to_reg=0, instr_count=1.
REQ-047 opcode=6, mem_ready delayed 3 cycles in MEM -> mem_addr_sel=1 for 4 cycles, then WB with reg_write=1 and mem_to_reg=1.
REQ-048 opcode=5: zero_flag=0 -> pc_write=1 and pc_src=1 in EXEC; zero_flag=1 -> no pc_write in EXEC; both return to FETCH.
REQ-049 mem_ready held 0 in FETCH -> bus_err=1 and halted=1 after 16 request cycles; rst_n pulse clears both.
REQ-050 opcode=9 -> illegal pulse of 1 cycle and FETCH next; opcode=15 -> halted=1 and run is ignored thereafter.
REQ-051 Preload instr_count to 0xFFFF via 65535 NOPs, then retire one more -> instr_count=0x0000.
